// File: rtl/hsv_core_commit_arbiter.sv
// rtl/hsv_core_commit_arbiter.sv - round-robin commit port arbiter with one-entry output stage
module hsv_core_commit_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           in_valid,
    output logic [NUM_SRC-1:0]           in_ready,
    input  logic [NUM_SRC-1:0][63:0]     in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [63:0]                  out_data,
    output logic [SRC_W-1:0]             out_src,
    output logic [CNT_W-1:0]             commit_count
);

    logic                 r_out_valid;
    logic [63:0]          r_out_data;
    logic [SRC_W-1:0]     r_out_src;
    logic [CNT_W-1:0]     r_commit_count;
    logic [SRC_W-1:0]     r_rr_ptr;

    logic                 w_can_load;
    logic                 w_found;
    logic [SRC_W-1:0]     w_winner;
    logic [SRC_W-1:0]     w_cand;
    logic [SRC_W-1:0]     w_rr_next;
    logic                 w_in_hs;
    logic                 w_out_hs;

    // Reset gates the grant path so nothing is accepted while rst_core is high.
    assign w_can_load = ~rst_core & ~flush & (~r_out_valid | out_ready);
    assign w_out_hs   = r_out_valid & out_ready;
    assign w_in_hs    = w_can_load & w_found;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_cand = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            if (!w_found && in_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            in_ready[i] = w_in_hs & (w_winner == SRC_W'(i)) & in_valid[i];
        end
    end

    assign w_rr_next = (int'(w_winner) == NUM_SRC - 1) ? '0 : w_winner + SRC_W'(1);

    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_src      <= '0;
            r_commit_count <= '0;
            r_rr_ptr       <= '0;
        end else begin
            if (w_out_hs) begin
                r_commit_count <= r_commit_count + CNT_W'(1);
            end
            if (w_in_hs) begin
                r_out_data  <= in_data[w_winner];
                r_out_src   <= w_winner;
                r_out_valid <= 1'b1;
                r_rr_ptr    <= w_rr_next;
            end else if (w_out_hs || flush) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_src      = r_out_src;
    assign commit_count = r_commit_count;

endmodule

// File: tb/tb_hsv_core_commit_arbiter.sv
// tb/tb_hsv_core_commit_arbiter.sv - directed self-checking bench for hsv_core_commit_arbiter
module tb_hsv_core_commit_arbiter;

    logic              clk_core = 1'b0;
    logic              rst_core;
    logic              flush;
    logic [3:0]        in_valid;
    logic [3:0]        in_ready;
    logic [3:0][63:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [1:0]        out_src;
    logic [31:0]       commit_count;

    int n_tests = 0;
    int n_fail  = 0;

    hsv_core_commit_arbiter #(.NUM_SRC(4), .SRC_W(2), .CNT_W(32)) dut (
        .clk_core     (clk_core),
        .rst_core     (rst_core),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_src      (out_src),
        .commit_count (commit_count)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each step: drive at the falling edge, settle, then compare.
    task automatic step(input logic [3:0] v, input logic ordy, input logic fl, input logic rst);
        @(negedge clk_core);
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        rst_core  = rst;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4; i++) in_data[i] = {32'h200 + 32'(i * 4), 32'hA0 + 32'(i)};
        rst_core = 1'b1; flush = 1'b0; in_valid = 4'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk_core);

        // Reset state
        step(4'b0000, 1'b0, 1'b0, 1'b0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_count", 64'(commit_count), 64'd0);

        // Single request from ALU
        in_data[0] = {32'h100, 32'h5};
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        check("t1_in_ready", 64'(in_ready), 64'h1);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_data", out_data, 64'h00000100_00000005);
        check("t1_out_src", 64'(out_src), 64'd0);
        check("t1_count0", 64'(commit_count), 64'd0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t1_count1", 64'(commit_count), 64'd1);
        check("t1_drained", 64'(out_valid), 64'd0);

        // Full contention after a fresh reset: 0,1,2,3,0,1,2,3
        in_data[0] = {32'h200, 32'hA0};
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b1, 1'b0, 1'b0);
            check($sformatf("t2_grant%0d", k), 64'(in_ready), 64'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check($sformatf("t2_src%0d", k), 64'(out_src), 64'((k - 1) % 4));
                check($sformatf("t2_data%0d", k), out_data,
                      {32'h200 + 32'(((k - 1) % 4) * 4), 32'hA0 + 32'((k - 1) % 4)});
            end
        end
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t2_last_src", 64'(out_src), 64'd3);
        check("t2_count7", 64'(commit_count), 64'd7);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t2_count8", 64'(commit_count), 64'd8);
        check("t2_drained", 64'(out_valid), 64'd0);

        // Backpressure: unit 0 granted, stall, then unit 2
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        check("t3_first", 64'(in_ready), 64'h1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, 1'b0, 1'b0, 1'b0);
            check($sformatf("t3_stall_rdy%0d", k), 64'(in_ready), 64'h0);
            check($sformatf("t3_stall_src%0d", k), 64'(out_src), 64'd0);
            check($sformatf("t3_stall_vld%0d", k), 64'(out_valid), 64'd1);
        end
        check("t3_stall_count", 64'(commit_count), 64'd8);
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        check("t3_release", 64'(in_ready), 64'h4);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t3_src2", 64'(out_src), 64'd2);
        check("t3_count9", 64'(commit_count), 64'd9);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t3_count10", 64'(commit_count), 64'd10);

        // Wrap-around: 3, then 0, then 3
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        check("t4_grant3", 64'(in_ready), 64'h8);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        check("t4_src3", 64'(out_src), 64'd3);
        check("t4_wrap0", 64'(in_ready), 64'h1);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        check("t4_src0", 64'(out_src), 64'd0);
        check("t4_then3", 64'(in_ready), 64'h8);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t4_src3b", 64'(out_src), 64'd3);
        check("t4_count12", 64'(commit_count), 64'd12);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t4_count13", 64'(commit_count), 64'd13);

        // Flush while draining src 1
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        check("t5_grant1", 64'(in_ready), 64'h2);
        step(4'b0100, 1'b1, 1'b1, 1'b0);
        check("t5_flush_rdy", 64'(in_ready), 64'h0);
        check("t5_src1", 64'(out_src), 64'd1);
        check("t5_vld", 64'(out_valid), 64'd1);
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        check("t5_flushed", 64'(out_valid), 64'd0);
        check("t5_count14", 64'(commit_count), 64'd14);
        check("t5_grant2", 64'(in_ready), 64'h4);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t5_src2", 64'(out_src), 64'd2);
        check("t5_vld2", 64'(out_valid), 64'd1);

        // Reset mid-transfer
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        check("t6_grant0", 64'(in_ready), 64'h1);
        check("t6_count15", 64'(commit_count), 64'd15);
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        check("t6_held", 64'(out_valid), 64'd1);
        check("t6_rst_rdy", 64'(in_ready), 64'h0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        check("t6_vld0", 64'(out_valid), 64'd0);
        check("t6_count0", 64'(commit_count), 64'd0);
        check("t6_data0", out_data, 64'd0);
        check("t6_first", 64'(in_ready), 64'h1);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        check("t6_src0", 64'(out_src), 64'd0);
        check("t6_dataA", out_data, {32'h200, 32'hA0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hsv_core_commit_arbiter.md
Name: hsv_core_commit_arbiter

Overview:
- Shares the single commit port between the four execute units: ALU, MEM, BRANCH and CTRL_STATUS.
- Each unit presents a commit_data_t (pc, result) through a valid/ready handshake.
- The arbiter grants one unit per cycle in round-robin order and registers the winner into a one-entry output stage that feeds the commit stage.
- It also keeps a running count of committed results and supports a pipeline flush.

Parameters:
- NUM_SRC, 4, number of requesting execute units. Index 0=ALU, 1=MEM, 2=BRANCH, 3=CTRL_STATUS.
- SRC_W, 2, width of the source index, equal to clog2(NUM_SRC).
- CNT_W, 32, width of the commit counter.

Ports:
- clk_core  in  1  core clock. All state updates on the rising edge.
- rst_core  in  1  synchronous, active-high reset.
- flush  in  1  discard the buffered result and block grants this cycle.
- in_valid  in  NUM_SRC  per-unit result valid.
- in_ready  out  NUM_SRC  per-unit accept. At most one bit set per cycle.
- in_data  in  NUM_SRC x 64  per-unit commit_data_t, packed {pc[63:32], result[31:0]}.
- out_valid  out  1  registered result available to the commit stage.
- out_ready  in  1  commit stage accepts out_data.
- out_data  out  64  registered commit_data_t of the granted unit.
- out_src  out  SRC_W  index of the unit that produced out_data.
- commit_count  out  CNT_W  number of completed out handshakes since reset.

Behaviour:
- Reset values, taking effect on the first edge with rst_core=1:
  - out_valid=0, out_data=0, out_src=0, commit_count=0.
  - Round-robin pointer rr_ptr=0, so unit 0 has highest priority.
  - in_ready=0 while rst_core=1.
- can_load = ~flush & (~out_valid | out_ready). The output stage accepts a new entry when it is empty or draining this cycle.
- Grant selection (combinational):
  - Search from rr_ptr upward, modulo NUM_SRC. The first i with in_valid[i]=1 wins.
  - in_ready[i] = can_load & (i == winner) & in_valid[i]. in_ready must not depend on out_data.
- Input handshake: in_valid[i] & in_ready[i]. On a handshake at edge t:
  - out_data <= in_data[i], out_src <= i, out_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_SRC. Wrap from index 3 gives 0.
- Latency: exactly one cycle from input handshake to out_valid. Throughput is one result per cycle when out_ready is held high.
- Output handshake: out_valid & out_ready.
  - commit_count increments by 1, wrapping modulo 2^CNT_W.
  - If there is no simultaneous input handshake, out_valid <= 0.
- Simultaneous output and input handshake in the same cycle: out_data is replaced, out_valid stays 1, commit_count increments.
- Backpressure:
  - While out_valid=1 and out_ready=0, all in_ready=0.
  - out_data, out_src and rr_ptr hold.
- No requesters: rr_ptr holds and no state changes except an output drain.
- Flush=1:
  - All in_ready=0 and out_valid <= 0 next edge. out_data/out_src may hold stale values.
  - rr_ptr holds.
  - If out_valid & out_ready in the flush cycle, the handshake still completes and commit_count increments.
- Flush and rst_core both high: reset wins.
- Reset asserted mid-transfer drops the buffered entry. No partial state survives.
- Requesters are not required to hold in_valid. The arbiter makes no fairness guarantee for a unit that deasserts in_valid before being granted.
- Starvation bound: a unit holding in_valid=1 is granted within NUM_SRC output-stage loads.

Test Plan:
- Reset, then in_valid=4'b0001, in_data[0]={pc=0x100, result=0x5}, out_ready=1 -> in_ready=4'b0001 in the same cycle. Next cycle out_valid=1, out_data=0x00000100_00000005, out_src=0. One cycle later commit_count=1.
- in_valid=4'b1111 held, out_ready=1, for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle. commit_count reaches 8 after the last output handshake.
- in_valid=4'b0101, out_ready=0 after the first grant -> out_src=0 is held and in_ready=0 throughout the stall. On release, unit 2 is granted next, not unit 0.
- Last grant was unit 3, then in_valid=4'b1001 -> unit 0 is granted (wrap-around). rr_ptr becomes 1, and unit 3 is granted on the following load.
- out_valid=1 (src 1), out_ready=1, flush=1, in_valid=4'b0100 -> no grant this cycle and commit_count increments. Next cycle out_valid=0. The cycle after, unit 2 is granted.
- out_valid=1 holding data, then rst_core=1 for 1 cycle with in_valid=4'b1111 -> out_valid=0, commit_count=0, in_ready=0 during reset. The first grant after reset goes to unit 0.
